ram_test: RTL and testbench

RAM_TEST -- requirements
Module: ram_test

---
 rtl/ram_test_pkg.sv | 9 +
 rtl/ram_test_clear_seq.sv | 41 ++++
 rtl/ram_test.sv | 72 +++++++
 tb/tb_ram_test.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ram_test_pkg.sv
// Shared widths and typedefs for the ram_test single-port RAM with power-up clear sweep.
package ram_test_pkg;
    localparam int DEF_ADDR_W = 15;
    localparam int DEF_DATA_W = 16;
    localparam int DEPTH      = 2 ** DEF_ADDR_W;

    typedef logic [DEF_ADDR_W-1:0] addr_t;
    typedef logic [DEF_DATA_W-1:0] data_t;
endpackage

// File: rtl/ram_test_clear_seq.sv
// Post-reset clear sweep: walks every address once, writing zero, then raises ready.
module ram_test_clear_seq
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    output logic              sweep_we,
    output logic [ADDR_W-1:0] sweep_addr,
    output logic              ready
);
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              ready_q, ready_d;

    always_comb begin
        cnt_d   = cnt_q;
        ready_d = ready_q;
        if (!ready_q) begin
            cnt_d = cnt_q + 1'b1;
            // ready rises on the same edge that clears the last word
            if (cnt_q == {ADDR_W{1'b1}}) begin
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign sweep_we   = ~ready_q & ~reset;
    assign sweep_addr = cnt_q;
    assign ready      = ready_q;
endmodule

// File: rtl/ram_test.sv
// Single-port RAM cleared to zero after every reset; define RAM_TEST_OUTREG_EN for an extra read-data register.
module ram_test
    import ram_test_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              wren,
    input  logic              rden,
    output logic [DATA_W-1:0] q,
    output logic              ready
);
    localparam int WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];

    logic              sweep_we;
    logic [ADDR_W-1:0] sweep_addr;
    logic              rd_en;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rd_q;

    ram_test_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
        .clock      (clock),
        .reset      (reset),
        .sweep_we   (sweep_we),
        .sweep_addr (sweep_addr),
        .ready      (ready)
    );

    // Read beats write when both are requested; user traffic only once the sweep is done.
    assign rd_en = ready & rden & ~reset;
    assign we    = sweep_we | (ready & wren & ~rden & ~reset);
    assign waddr = ready ? address : sweep_addr;
    assign wdata = ready ? data : '0;

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= '0;
        end else if (rd_en) begin
            rd_q <= mem[address];
        end
    end

`ifdef RAM_TEST_OUTREG_EN
    logic [DATA_W-1:0] out_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= rd_q;
        end
    end

    assign q = out_q;
`else
    assign q = rd_q;
`endif
endmodule

// File: tb/tb_ram_test.sv
// Directed self-checking bench for ram_test at ADDR_W=4 (honours RAM_TEST_OUTREG_EN).
module tb_ram_test;
    localparam int AW = 4;
    localparam int DW = 16;
`ifdef RAM_TEST_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data = '0;
    logic          wren = 1'b0;
    logic          rden = 1'b0;
    logic [DW-1:0] q;
    logic          ready;

    int checks = 0;
    int errors = 0;

    ram_test #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .data    (data),
        .wren    (wren),
        .rden    (rden),
        .q       (q),
        .ready   (ready)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        address = a;
        data    = d;
        wren    = 1'b1;
        tick();
        wren    = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
        address = a;
        rden    = 1'b1;
        tick();
        rden    = 1'b0;
        repeat (LAT - 1) tick();
        check_eq(tag, {16'h0, q}, {16'h0, exp});
    endtask

    // Release reset and count cycles until ready; a stuck sweep is bounded.
    task automatic sweep(input string tag);
        int n;
        reset = 1'b0;
        n = 0;
        while (!ready && n < 40) begin
            tick();
            n++;
        end
        check_eq(tag, n, 16);
    endtask

    initial begin
        reset = 1'b1;
        tick();
        tick();
        check_eq("rst_q", {16'h0, q}, 32'h0);
        check_eq("rst_ready", {31'h0, ready}, 32'h0);

        // User write to 0x7 held during the whole sweep must be ignored
        address = 4'h7;
        data    = 16'hAAAA;
        wren    = 1'b1;
        sweep("sweep1_len");
        wren = 1'b0;
        check_eq("ready_after_sweep", {31'h0, ready}, 32'h1);

        for (int i = 0; i < 16; i++) begin
            do_read(i[AW-1:0], 16'h0000, $sformatf("clr_rd_%0d", i));
        end

        do_write(4'h3, 16'hBEEF);
        do_read(4'h3, 16'hBEEF, "wr_rd_3");
        tick();
        tick();
        check_eq("q_hold", {16'h0, q}, 32'hBEEF);

        // Simultaneous read and write: read wins, write dropped
        address = 4'h5;
        data    = 16'h1234;
        wren    = 1'b1;
        rden    = 1'b1;
        tick();
        wren = 1'b0;
        rden = 1'b0;
        repeat (LAT - 1) tick();
        check_eq("collide_q", {16'h0, q}, 32'h0);
        do_read(4'h5, 16'h0000, "collide_mem5");
        do_read(4'h7, 16'h0000, "sweep_wr_ignored_7");

        for (int i = 0; i < 16; i++) begin
            do_write(i[AW-1:0], 16'(i));
        end
        do_read(4'h9, 16'h0009, "fill_rd_9");
        do_read(4'hF, 16'h000F, "fill_rd_F");

        // Reset, then abort the following sweep at count 8
        reset = 1'b1;
        tick();
        check_eq("rst2_q", {16'h0, q}, 32'h0);
        reset = 1'b0;
        repeat (8) tick();
        check_eq("mid_sweep_ready", {31'h0, ready}, 32'h0);
        reset = 1'b1;
        tick();
        check_eq("rst3_q", {16'h0, q}, 32'h0);
        check_eq("rst3_ready", {31'h0, ready}, 32'h0);
        tick();
        sweep("sweep2_len");
        for (int i = 0; i < 16; i++) begin
            do_read(i[AW-1:0], 16'h0000, $sformatf("reclr_rd_%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
